// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, ALU operation codes and FSM state encoding for the multi-cycle control unit.
package mc_ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LW   = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SW   = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_WB     = 4'd6,
    ST_BRANCH = 4'd7,
    ST_HALT   = 4'd8
  } state_e;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational opcode classifier: ALU operation, B-operand select and instruction class bits.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_imm_o,
  output logic                is_exec_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_branch_o,
  output logic                is_halt_o
);

  // Classify the opcode; anything unlisted decodes as a NOP.
  always_comb begin
    alu_op_o      = ALU_ADD;
    alu_src_imm_o = 1'b0;
    is_exec_o     = 1'b0;
    is_load_o     = 1'b0;
    is_store_o    = 1'b0;
    is_branch_o   = 1'b0;
    is_halt_o     = 1'b0;
    case (opcode_i)
      OP_ADD:  begin is_exec_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_SUB:  begin is_exec_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_AND:  begin is_exec_o = 1'b1; alu_op_o = ALU_AND; end
      OP_OR:   begin is_exec_o = 1'b1; alu_op_o = ALU_OR;  end
      OP_ADDI: begin is_exec_o = 1'b1; alu_src_imm_o = 1'b1; end
      OP_LW:   begin is_exec_o = 1'b1; alu_src_imm_o = 1'b1; is_load_o = 1'b1; end
      OP_SW:   begin is_exec_o = 1'b1; alu_src_imm_o = 1'b1; is_store_o = 1'b1; end
      OP_BEQ:  begin is_branch_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback with a memory-stall watchdog.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] IR_OPCODE,
  input  logic                MEM_READY,
  input  logic                ZERO,
  output logic                PC_WE,
  output logic                PC_SRC,
  output logic                IR_WE,
  output logic                ADDR_SEL,
  output logic                MEM_RE,
  output logic                MEM_WE,
  output logic                ALU_SRC_IMM,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                REG_WE,
  output logic                WB_SEL,
  output logic                HALTED,
  output logic                ERR
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic                err_q, err_d;
  logic                mem_wait;

  logic                pc_src_q, pc_src_d;
  logic                addr_sel_q, addr_sel_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic                alu_src_imm_q, alu_src_imm_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                reg_we_q, reg_we_d;
  logic                wb_sel_q, wb_sel_d;
  logic                halted_q, halted_d;
  logic                fetch_q, fetch_d;
  logic                branch_q, branch_d;

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_src_imm, dec_exec, dec_load, dec_store, dec_branch, dec_halt;

  mc_alu_decode u_alu_decode (
    .opcode_i      (IR_OPCODE),
    .alu_op_o      (dec_alu_op),
    .alu_src_imm_o (dec_src_imm),
    .is_exec_o     (dec_exec),
    .is_load_o     (dec_load),
    .is_store_o    (dec_store),
    .is_branch_o   (dec_branch),
    .is_halt_o     (dec_halt)
  );

  // Next state, watchdog and the output values that will hold in the next state.
  always_comb begin
    state_d  = state_q;
    wd_d     = '0;
    err_d    = err_q;
    mem_wait = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (MEM_READY) state_d = ST_DECODE; else mem_wait = 1'b1;
      ST_DECODE: begin
        if      (dec_exec)   state_d = ST_EXEC;
        else if (dec_branch) state_d = ST_BRANCH;
        else if (dec_halt)   state_d = ST_HALT;
        else                 state_d = ST_FETCH;
      end
      ST_EXEC: begin
        if      (dec_load)  state_d = ST_MEMRD;
        else if (dec_store) state_d = ST_MEMWR;
        else                state_d = ST_WB;
      end
      ST_MEMRD:  if (MEM_READY) state_d = ST_WB;    else mem_wait = 1'b1;
      ST_MEMWR:  if (MEM_READY) state_d = ST_FETCH; else mem_wait = 1'b1;
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    // A wait on the last allowed cycle expires; MEM_READY on that cycle never reaches here.
    if (mem_wait) begin
      if ((MEM_TIMEOUT != 0) && (wd_q == CNT_W'(MEM_TIMEOUT - 1))) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + CNT_W'(1);
      end
    end

    pc_src_d      = (state_d == ST_BRANCH);
    addr_sel_d    = (state_d == ST_MEMRD) || (state_d == ST_MEMWR);
    mem_re_d      = (state_d == ST_FETCH) || (state_d == ST_MEMRD);
    mem_we_d      = (state_d == ST_MEMWR);
    alu_src_imm_d = (state_d == ST_EXEC) && dec_src_imm;
    alu_op_d      = (state_d == ST_EXEC)   ? dec_alu_op :
                    (state_d == ST_BRANCH) ? ALU_SUB    : ALU_ADD;
    reg_we_d      = (state_d == ST_WB);
    wb_sel_d      = (state_d == ST_WB) && dec_load;
    halted_d      = (state_d == ST_HALT);
    fetch_d       = (state_d == ST_FETCH);
    branch_d      = (state_d == ST_BRANCH);
  end

  // State, watchdog, sticky error and registered outputs; reset clears strobes immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      err_q         <= 1'b0;
      pc_src_q      <= 1'b0;
      addr_sel_q    <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= ALU_ADD;
      reg_we_q      <= 1'b0;
      wb_sel_q      <= 1'b0;
      halted_q      <= 1'b0;
      fetch_q       <= 1'b0;
      branch_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      err_q         <= err_d;
      pc_src_q      <= pc_src_d;
      addr_sel_q    <= addr_sel_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      alu_src_imm_q <= alu_src_imm_d;
      alu_op_q      <= alu_op_d;
      reg_we_q      <= reg_we_d;
      wb_sel_q      <= wb_sel_d;
      halted_q      <= halted_d;
      fetch_q       <= fetch_d;
      branch_q      <= branch_d;
    end
  end

  // IR/PC loads complete in the cycle memory answers; a branch commits on this cycle's ZERO.
  assign IR_WE       = fetch_q && MEM_READY;
  assign PC_WE       = (fetch_q && MEM_READY) || (branch_q && ZERO);
  assign PC_SRC      = pc_src_q;
  assign ADDR_SEL    = addr_sel_q;
  assign MEM_RE      = mem_re_q;
  assign MEM_WE      = mem_we_q;
  assign ALU_SRC_IMM = alu_src_imm_q;
  assign ALU_OP      = alu_op_q;
  assign REG_WE      = reg_we_q;
  assign WB_SEL      = wb_sel_q;
  assign HALTED      = halted_q;
  assign ERR         = err_q;

endmodule
